kgp_multicycle_ctrl: RTL and testbench
======================================

// Module: kgp_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the KGPminiRISC datapath: sequences fetch/decode/execute/mem/writeback.
//  Drives immediate-select mux (imm_sel = instr[27]: 1 = mem-type imm, 0 = I-type imm), ALU src, PC, RF, memories.
//  Sits between the instruction register / datapath and the instruction + data memory handshakes.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for imem_ack/dmem_ack before ERR; 0 = timeout disabled
//  TW           5   width of wait counter (2**TW-1 >= MEM_TIMEOUT)
// PORTS
//  clk          in   1   sole clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  instr        in   32  IR contents; opcode = instr[31:26], imm select bit = instr[27]
//  alu_zero     in   1   ALU zero flag, valid in EXEC
//  imem_req     out  1   instruction fetch request
//  imem_ack     in   1   fetch data valid this cycle
//  dmem_req     out  1   data memory request
//  dmem_we      out  1   1 = store, 0 = load; valid while dmem_req=1
//  dmem_ack     in   1   data access complete this cycle
//  ir_we        out  1   load IR
//  pc_we        out  1   update PC
//  pc_src       out  1   0 = PC+4, 1 = branch target
//  imm_sel      out  1   immediate mux select (to mem-type/I-type imm mux)
//  alu_src_imm  out  1   ALU operand B = immediate
//  reg_we       out  1   register file write enable
//  wb_sel       out  1   0 = ALU result, 1 = load data
//  halted       out  1   sticky, HALT executed
//  err          out  1   sticky, illegal opcode or memory timeout
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0, opcode latch=0; every output 0 in the cycle after rst sampled high.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR (Moore outputs from state + latched opcode).
//  IDLE   -> FETCH unconditionally (one cycle).
//  FETCH  imem_req=1; on imem_ack: ir_we=1, pc_we=1, pc_src=0, -> DECODE.
//  DECODE latch opcode; imm_sel=instr[27]; RTYPE 000000/ITYPE 000001/LD 000010/ST 000011/BR 000100 -> EXEC;
//         HALT 111111 -> HALT; any other opcode -> ERR.
//  EXEC   alu_src_imm=1 for ITYPE/LD/ST; imm_sel held; RTYPE/ITYPE -> WB; LD/ST -> MEM;
//         BR: pc_we=alu_zero, pc_src=1, -> FETCH.
//  MEM    dmem_req=1, dmem_we=(ST); req/we stable until ack; on ack: ST -> FETCH, LD -> WB.
//  WB     reg_we=1 for exactly one cycle; wb_sel=(LD); -> FETCH.
//  HALT   halted=1, all strobes 0; stays until rst.  ERR: err=1, all strobes 0; stays until rst.
//  Latency (ack in first wait cycle): RTYPE/ITYPE 4, BR 3, ST 4, LD 5 cycles FETCH-to-FETCH.
//  Wait counter: cleared on entry to FETCH/MEM, +1 per cycle without ack; at == MEM_TIMEOUT -> ERR.
//  Ack in same cycle counter reaches MEM_TIMEOUT: ack wins, normal transition.
//  Ack outside FETCH/MEM: ignored. Counter saturates, never wraps.
//  rst mid-operation (incl. during outstanding req): req drops at that edge; no pc_we/reg_we/ir_we issued.
//  imm_sel, alu_src_imm, wb_sel = 0 whenever not meaningful (IDLE/FETCH/HALT/ERR).
// STRUCTURE
//  Shared include kgp_defines.vh: opcode constants (OP_RTYPE..OP_HALT), state encodings, PC_SRC_* values.
//  One sub-module: kgp_wait_timer (clear, tick, ack -> timeout flag), instantiated once, shared by FETCH/MEM.
//  FSM + output decode in the top module; no combinational path ack -> req.
// TESTING
//  rst=1 2 cycles, release -> all outputs 0 for IDLE, imem_req=1 the next cycle.
//  ADDI (op 000001, instr[27]=0), ack at once -> imm_sel=0, alu_src_imm=1, reg_we pulse, 4 cycles total.
//  LD (op 000010, instr[27]=1), dmem_ack after 3 waits -> imm_sel=1, dmem_we=0 held, wb_sel=1, reg_we 1 cycle.
//  BR with alu_zero=1 then 0 -> pc_we=1,pc_src=1 first; pc_we=0 second; both return to FETCH.
//  MEM_TIMEOUT=4, no dmem_ack -> err=1 after 4 wait cycles; ack on 4th cycle instead -> no err.
//  Opcode 101010 -> err=1 sticky; HALT -> halted=1; rst mid-MEM -> dmem_req 0 next cycle, IDLE.

Source files
------------

// File: rtl/kgp_multicycle_ctrl_pkg.sv
// Shared types and constants for the KGPminiRISC multi-cycle controller:
// FSM state encoding, opcode values and PC source selections.
package kgp_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_ITYPE = 6'b000001;
  localparam opcode_t OP_LD    = 6'b000010;
  localparam opcode_t OP_ST    = 6'b000011;
  localparam opcode_t OP_BR    = 6'b000100;
  localparam opcode_t OP_HALT  = 6'b111111;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_BR  = 1'b1;

  function automatic logic is_exec_op(input opcode_t op);
    return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LD) ||
           (op == OP_ST) || (op == OP_BR);
  endfunction

  function automatic logic uses_imm(input opcode_t op);
    return (op == OP_ITYPE) || (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/kgp_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-memory handshakes; flags a
// timeout when the access would exceed TIMEOUT unacknowledged cycles.
module kgp_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  input  logic ack,
  output logic timeout
);

  localparam logic [TW-1:0] LIMIT   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] MAX_CNT = '1;

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear || ack) begin
      count <= '0;
    end else if (tick && (count != MAX_CNT)) begin
      count <= count + 1'b1;
    end
  end

  // Fires in the cycle that would be the TIMEOUT-th wait; an ack that cycle wins.
  assign timeout = (TIMEOUT != 0) && tick && !ack && (count == LIMIT);

endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// Multi-cycle control FSM for the KGPminiRISC datapath: sequences
// fetch/decode/execute/mem/writeback and drives datapath and memory strobes.
module kgp_multicycle_ctrl
  import kgp_multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        imm_sel,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        halted,
  output logic        err
);

  // Valid/ready handshake: a request is held high and stable from state entry
  // until the matching ack is seen high on a rising edge; ack completes it.

  state_t  state, state_next;
  opcode_t op_q;
  logic    waiting;
  logic    cur_ack;
  logic    timeout;
  logic    unused_instr_bits;

  assign unused_instr_bits = ^instr[25:0];

  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign cur_ack = (state == S_FETCH) ? imem_ack : dmem_ack;

  kgp_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT),
    .TW      (TW)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .tick    (waiting),
    .ack     (cur_ack),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_q <= instr[31:26];
      end
    end
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_SRC_SEQ;
    imm_sel     = 1'b0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;

    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_ERR;
        end
      end
      S_DECODE: begin
        imm_sel = instr[27];
        if (is_exec_op(instr[31:26])) begin
          state_next = S_EXEC;
        end else if (instr[31:26] == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          state_next = S_ERR;
        end
      end
      S_EXEC: begin
        // instr[27] is opcode bit 1, so the latched opcode keeps imm_sel stable.
        imm_sel     = op_q[1];
        alu_src_imm = uses_imm(op_q);
        case (op_q)
          OP_RTYPE, OP_ITYPE: state_next = S_WB;
          OP_LD, OP_ST:       state_next = S_MEM;
          OP_BR: begin
            pc_src     = PC_SRC_BR;
            pc_we      = alu_zero;
            state_next = S_FETCH;
          end
          default:            state_next = S_ERR;
        endcase
      end
      S_MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = (op_q == OP_ST);
        imm_sel     = op_q[1];
        alu_src_imm = 1'b1;
        if (dmem_ack) begin
          state_next = (op_q == OP_ST) ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_next = S_ERR;
        end
      end
      S_WB: begin
        reg_we      = 1'b1;
        wb_sel      = (op_q == OP_LD);
        imm_sel     = op_q[1];
        alu_src_imm = uses_imm(op_q);
        state_next  = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   err    = 1'b1;
      default: state_next = S_ERR;
    endcase

    // A reset edge must never also commit architectural state.
    if (rst) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      reg_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Bench for kgp_multicycle_ctrl: an instruction-level model expands each
// instruction into expected per-cycle outputs that are replayed against the DUT.
module tb_kgp_multicycle_ctrl;

  localparam int T = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ITYPE = 6'b000001;
  localparam logic [5:0] OP_LD    = 6'b000010;
  localparam logic [5:0] OP_ST    = 6'b000011;
  localparam logic [5:0] OP_BR    = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [11:0] M_IREQ  = 12'h800;
  localparam logic [11:0] M_DREQ  = 12'h400;
  localparam logic [11:0] M_DWE   = 12'h200;
  localparam logic [11:0] M_IRWE  = 12'h100;
  localparam logic [11:0] M_PCWE  = 12'h080;
  localparam logic [11:0] M_PCSRC = 12'h040;
  localparam logic [11:0] M_IMM   = 12'h020;
  localparam logic [11:0] M_ASRC  = 12'h010;
  localparam logic [11:0] M_REGWE = 12'h008;
  localparam logic [11:0] M_WBSEL = 12'h004;
  localparam logic [11:0] M_HALT  = 12'h002;
  localparam logic [11:0] M_ERR   = 12'h001;
  localparam logic [11:0] M_ALL   = 12'hFFF;
  localparam logic [11:0] M_BASE  = M_ALL & ~M_DWE;
  localparam logic [11:0] M_STRB  = M_IRWE | M_PCWE | M_REGWE;

  typedef struct packed {
    logic        ia;
    logic        da;
    logic        az;
    logic [31:0] ins;
    logic [11:0] exp;
    logic [11:0] mask;
  } cyc_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        alu_zero, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src;
  logic        imm_sel, alu_src_imm, reg_we, wb_sel, halted, err;
  logic [11:0] obs;

  always #5 clk = ~clk;

  kgp_multicycle_ctrl #(.MEM_TIMEOUT(T), .TW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .imm_sel     (imm_sel),
    .alu_src_imm (alu_src_imm),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .halted      (halted),
    .err         (err)
  );

  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
                imm_sel, alu_src_imm, reg_we, wb_sel, halted, err};

  // ---------------- scoreboard ----------------
  cyc_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%b want=%b (t=%0t)", tag, got, want, $time);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] r32();
    return $urandom;
  endfunction

  task automatic push(input string tag, input logic [31:0] ins, input logic ia,
                      input logic da, input logic az, input logic [11:0] e,
                      input logic [11:0] m);
    cyc_t c;
    c.ia = ia; c.da = da; c.az = az; c.ins = ins; c.exp = e; c.mask = m;
    exp_q.push_back(c);
    tag_q.push_back(tag);
  endtask

  task automatic push_stuck(input string tag, input logic [11:0] flag);
    for (int i = 0; i < 3; i++) push(tag, r32(), rbit(), rbit(), rbit(), flag, M_BASE);
  endtask

  // ---------------- reference model ----------------
  // Expands one instruction into cycles. fw/mw = unacknowledged cycles before the
  // ack; fw or mw >= T means no ack arrives in time. cut>0 stops after cut MEM waits.
  task automatic model_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic az, input int cut, output bit dead);
    logic [31:0] ins;
    logic        i27, is_ld, is_st, is_br, legal, imm_op;
    ins    = {op, 26'($urandom)};
    i27    = ins[27];
    is_ld  = (op == OP_LD);
    is_st  = (op == OP_ST);
    is_br  = (op == OP_BR);
    legal  = (op <= 6'd4);
    imm_op = (op == OP_ITYPE) || is_ld || is_st;
    dead   = 1'b0;

    for (int i = 0; i < fw && i < T; i++) push("fetch_wait", r32(), 1'b0, rbit(), rbit(), M_IREQ, M_BASE);
    if (fw >= T) begin
      push_stuck("fetch_timeout", M_ERR);
      dead = 1'b1;
      return;
    end
    push("fetch_ack", r32(), 1'b1, rbit(), rbit(), M_IREQ | M_IRWE | M_PCWE, M_BASE);
    push("decode", ins, rbit(), rbit(), rbit(), i27 ? M_IMM : 12'h000,
         M_BASE & ~(M_ASRC | M_WBSEL | M_PCSRC));
    if (op == OP_HALT) begin
      push_stuck("halt", M_HALT);
      dead = 1'b1;
      return;
    end
    if (!legal) begin
      push_stuck("illegal", M_ERR);
      dead = 1'b1;
      return;
    end
    push("exec", r32(), rbit(), rbit(), az,
         (i27 ? M_IMM : 12'h000) | (imm_op ? M_ASRC : 12'h000) |
         (is_br ? M_PCSRC : 12'h000) | ((is_br && az) ? M_PCWE : 12'h000),
         M_BASE & ~M_WBSEL);
    if (is_br) return;
    if (is_ld || is_st) begin
      for (int i = 0; i < mw && i < T; i++) begin
        if (cut > 0 && i == cut) return;
        push("mem_wait", r32(), rbit(), 1'b0, rbit(), M_DREQ | (is_st ? M_DWE : 12'h000),
             M_ALL & ~(M_IMM | M_ASRC | M_WBSEL | M_PCSRC));
      end
      if (cut > 0) return;
      if (mw >= T) begin
        push_stuck("mem_timeout", M_ERR);
        dead = 1'b1;
        return;
      end
      push("mem_ack", r32(), rbit(), 1'b1, rbit(), M_DREQ | (is_st ? M_DWE : 12'h000),
           M_ALL & ~(M_IMM | M_ASRC | M_WBSEL | M_PCSRC));
      if (is_st) return;
    end
    push("wb", r32(), rbit(), rbit(), rbit(), M_REGWE | (is_ld ? M_WBSEL : 12'h000),
         M_BASE & ~(M_IMM | M_ASRC | M_PCSRC));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; applies each cycle's inputs and samples mid-cycle.
  task automatic drain();
    cyc_t  c;
    string t;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      t = tag_q.pop_front();
      imem_ack = c.ia; dmem_ack = c.da; alu_zero = c.az; instr = c.ins;
      @(negedge clk);
      check_eq(t, obs & c.mask, c.exp & c.mask);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    drain();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; instr = r32();
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("reset_outputs", obs, 12'h000);
    @(posedge clk); #1;
    rst = 1'b0;
    push("idle", r32(), rbit(), rbit(), rbit(), 12'h000, M_ALL);
  endtask

  // Assert reset in the current cycle with acks high: no strobe may fire, and
  // every request must be gone by the next cycle.
  task automatic rst_mid(input string tag);
    drain();
    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    check_eq({tag, "_strobes"}, obs & M_STRB, 12'h000);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_after"}, obs, 12'h000);
    @(posedge clk); #1;
    rst = 1'b0;
    push("idle", r32(), rbit(), rbit(), rbit(), 12'h000, M_ALL);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit         dead;
    logic [5:0] op;
    int         r, fw, mw;
    rst = 1'b1; instr = '0; alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

    do_reset();
    model_instr(OP_ITYPE, 0, 0, 1'b0, 0, dead);
    model_instr(OP_LD,    0, 3, 1'b0, 0, dead);
    model_instr(OP_BR,    0, 0, 1'b1, 0, dead);
    model_instr(OP_BR,    0, 0, 1'b0, 0, dead);
    model_instr(OP_ST,    2, 1, 1'b1, 0, dead);
    model_instr(OP_RTYPE, 1, 0, 1'b0, 0, dead);
    rst_mid("rst_fetch");

    model_instr(OP_ST, 0, 3, 1'b0, 0, dead);
    model_instr(OP_LD, 0, T, 1'b0, 0, dead);
    do_reset();
    model_instr(OP_ITYPE, T, 0, 1'b0, 0, dead);
    do_reset();
    model_instr(6'b101010, 0, 0, 1'b0, 0, dead);
    do_reset();
    model_instr(OP_HALT, 1, 0, 1'b0, 0, dead);
    do_reset();
    model_instr(OP_LD, 0, T, 1'b0, 2, dead);
    rst_mid("rst_mem");

    for (int p = 0; p < 50; p++) begin
      do_reset();
      for (int k = 0; k < 15; k++) begin
        r  = $urandom_range(0, 19);
        fw = $urandom_range(0, 3);
        mw = $urandom_range(0, 4);
        if (r < 4) op = OP_RTYPE;
        else if (r < 8) op = OP_ITYPE;
        else if (r < 11) op = OP_LD;
        else if (r < 14) op = OP_ST;
        else if (r < 17) op = OP_BR;
        else if (r == 17) op = OP_HALT;
        else if (r == 18) begin
          op = 6'($urandom);
          while (op <= 6'd4 || op == OP_HALT) op = 6'($urandom);
        end else begin
          op = OP_ITYPE;
          fw = T;
        end
        model_instr(op, fw, mw, rbit(), 0, dead);
        if (dead) break;
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
